cond_select_skid: RTL and testbench

- Registered valid/ready skid stage directly downstream of the combinational if / else-if / else select logic.
- Captures each selected result from the upstream select and presents it to the consumer with full-throughput, back-pressure-safe handshaking.
- Provides a synchronous flush.
- There is no combinational path from the output handshake to the input handshake, so the select logic and the consumer are timing-isolated.

---
 rtl/cond_select_skid.sv | 126 ++++++++++++
 tb/tb_cond_select_skid.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/cond_select_skid.sv
// Registered valid/ready skid stage behind the combinational select logic; main + skid register, FIFO order.
// Optional output-transfer counter o_xfer_cnt is built when COND_SELECT_SKID_CNT_EN is defined.
module cond_select_skid #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_flush,
  input  logic                 i_valid,
  input  logic [WIDTH-1:0]     i_data,
  output logic                 i_ready,
`ifdef COND_SELECT_SKID_CNT_EN
  output logic [CNT_WIDTH-1:0] o_xfer_cnt,
`endif
  output logic                 o_valid,
  output logic [WIDTH-1:0]     o_data,
  input  logic                 o_ready
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] main_q, main_d;
  logic [WIDTH-1:0] skid_q, skid_d;
  logic             o_valid_q, o_valid_d;
  logic             i_ready_q, i_ready_d;
  logic             in_xfer;
  logic             out_xfer;

  assign in_xfer  = i_valid && i_ready_q;
  assign out_xfer = o_valid_q && o_ready;

  // State register and data storage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= EMPTY;
      main_q    <= '0;
      skid_q    <= '0;
      o_valid_q <= 1'b0;
      i_ready_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      main_q    <= main_d;
      skid_q    <= skid_d;
      o_valid_q <= o_valid_d;
      i_ready_q <= i_ready_d;
    end
  end

  // Next-state, data steering and registered handshake outputs
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    unique case (state_q)
      EMPTY: begin
        if (in_xfer) begin
          state_d = ONE;
          main_d  = i_data;
        end
      end
      ONE: begin
        if (in_xfer && out_xfer) begin
          main_d = i_data;
        end else if (in_xfer) begin
          state_d = FULL;
          skid_d  = i_data;
        end else if (out_xfer) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        if (out_xfer) begin
          state_d = ONE;
          main_d  = skid_q;
        end
      end
      default: begin
        state_d = EMPTY;
      end
    endcase
    // Flush wins over any handshake this cycle; data registers may keep stale values
    if (i_flush) begin
      state_d = EMPTY;
    end
    o_valid_d = (state_d != EMPTY);
    i_ready_d = (state_d != FULL);
  end

  assign o_valid = o_valid_q;
  assign i_ready = i_ready_q;
  assign o_data  = main_q;

`ifdef COND_SELECT_SKID_CNT_EN
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

  // Saturating output-transfer counter; flush clear beats a same-cycle transfer
  always_comb begin
    cnt_d = cnt_q;
    if (i_flush) begin
      cnt_d = '0;
    end else if (out_xfer && (cnt_q != {CNT_WIDTH{1'b1}})) begin
      cnt_d = cnt_q + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign o_xfer_cnt = cnt_q;
`else
  logic cnt_width_unused;
  assign cnt_width_unused = ^32'(CNT_WIDTH);
`endif

endmodule

// File: tb/tb_cond_select_skid.sv
// Scoreboard bench for cond_select_skid: directed vectors, expected words queued on accept, popped by a monitor.
module tb_cond_select_skid;

`ifdef COND_SELECT_SKID_CNT_EN
  localparam int unsigned CW = 4;
`else
  localparam int unsigned CW = 16;
`endif

  logic       clk;
  logic       rst_n;
  logic       i_flush;
  logic       i_valid;
  logic [7:0] i_data;
  logic       i_ready;
  logic       o_valid;
  logic [7:0] o_data;
  logic       o_ready;
`ifdef COND_SELECT_SKID_CNT_EN
  logic [CW-1:0] o_xfer_cnt;
`endif

  int vectors     = 0;
  int miscompares = 0;
  logic [7:0] exp_q[$];

  cond_select_skid #(.WIDTH(8), .CNT_WIDTH(CW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_flush    (i_flush),
    .i_valid    (i_valid),
    .i_data     (i_data),
    .i_ready    (i_ready),
`ifdef COND_SELECT_SKID_CNT_EN
    .o_xfer_cnt (o_xfer_cnt),
`endif
    .o_valid    (o_valid),
    .o_data     (o_data),
    .o_ready    (o_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every output handshake (sampled at negedge, completes at next posedge) pops one expected word
  always @(negedge clk) begin
    if (rst_n && o_valid && o_ready) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL scoreboard_underflow: got 0x%0h expected no output at %0t", o_data, $time);
      end else begin
        chk("scoreboard_data", 32'(o_data), 32'(exp_q.pop_front()));
      end
    end
  end

  // One cycle: drive after posedge, return at negedge; queue the word if it will be accepted
  task automatic drive(input logic v, input logic [7:0] d, input logic fl, input logic rdy);
    @(posedge clk);
    #1;
    i_valid = v;
    i_data  = d;
    i_flush = fl;
    o_ready = rdy;
    @(negedge clk);
    if (v && i_ready && !fl) begin
      exp_q.push_back(d);
    end
    if (fl) begin
      #1;
      exp_q.delete();
    end
  endtask

  initial begin
    rst_n   = 1'b0;
    i_flush = 1'b0;
    i_valid = 1'b0;
    i_data  = 8'h00;
    o_ready = 1'b0;

    // Reset and idle
    repeat (3) @(negedge clk);
    chk("rst_o_valid", 32'(o_valid), 32'd0);
    chk("rst_i_ready", 32'(i_ready), 32'd1);
    chk("rst_o_data", 32'(o_data), 32'd0);
`ifdef COND_SELECT_SKID_CNT_EN
    chk("rst_cnt", 32'(o_xfer_cnt), 32'd0);
`endif
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      drive(1'b0, 8'h00, 1'b0, 1'b0);
      chk("idle_o_valid", 32'(o_valid), 32'd0);
      chk("idle_i_ready", 32'(i_ready), 32'd1);
    end

    // Streaming 0x01..0x10 at full rate, 1-cycle latency, no bubbles
    for (int k = 1; k <= 17; k++) begin
      if (k <= 16) begin
        drive(1'b1, 8'(k), 1'b0, 1'b1);
        chk("stream_i_ready", 32'(i_ready), 32'd1);
      end else begin
        drive(1'b0, 8'h00, 1'b0, 1'b1);
      end
      if (k >= 2) begin
        chk("stream_o_valid", 32'(o_valid), 32'd1);
        chk("stream_o_data", 32'(o_data), 32'(k - 1));
      end
    end
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    chk("stream_drain_o_valid", 32'(o_valid), 32'd0);

    // Back-pressure: fill to FULL, hold, then drain in order
    drive(1'b1, 8'hA5, 1'b0, 1'b0);
    chk("bp_i_ready0", 32'(i_ready), 32'd1);
    drive(1'b1, 8'h5A, 1'b0, 1'b0);
    chk("bp_i_ready1", 32'(i_ready), 32'd1);
    chk("bp_o_data1", 32'(o_data), 32'hA5);
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 8'h00, 1'b0, 1'b0);
      chk("bp_full_i_ready", 32'(i_ready), 32'd0);
      chk("bp_hold_o_valid", 32'(o_valid), 32'd1);
      chk("bp_hold_o_data", 32'(o_data), 32'hA5);
    end
    drive(1'b0, 8'h00, 1'b0, 1'b1);
    chk("bp_out0_data", 32'(o_data), 32'hA5);
    chk("bp_out0_i_ready", 32'(i_ready), 32'd0);
    drive(1'b0, 8'h00, 1'b0, 1'b1);
    chk("bp_out1_data", 32'(o_data), 32'h5A);
    chk("bp_out1_i_ready", 32'(i_ready), 32'd1);
    drive(1'b0, 8'h00, 1'b0, 1'b1);
    chk("bp_empty_o_valid", 32'(o_valid), 32'd0);

    // Flush from FULL with a simultaneous input
    drive(1'b1, 8'h11, 1'b0, 1'b0);
    drive(1'b1, 8'h22, 1'b0, 1'b0);
    drive(1'b1, 8'h33, 1'b1, 1'b0);
    chk("fl_full_i_ready", 32'(i_ready), 32'd0);
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    chk("fl_o_valid", 32'(o_valid), 32'd0);
    chk("fl_i_ready", 32'(i_ready), 32'd1);
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 8'h00, 1'b0, 1'b1);
      chk("fl_after_o_valid", 32'(o_valid), 32'd0);
    end

    // Flush from ONE discards an accepted-looking input handshake
    drive(1'b1, 8'h44, 1'b0, 1'b0);
    drive(1'b1, 8'h55, 1'b1, 1'b0);
    chk("fl1_i_ready", 32'(i_ready), 32'd1);
    drive(1'b0, 8'h00, 1'b0, 1'b1);
    chk("fl1_o_valid", 32'(o_valid), 32'd0);
    drive(1'b0, 8'h00, 1'b0, 1'b1);
    chk("fl1_after_o_valid", 32'(o_valid), 32'd0);

    // Asynchronous reset while FULL
    drive(1'b1, 8'h66, 1'b0, 1'b0);
    drive(1'b1, 8'h77, 1'b0, 1'b0);
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    chk("ar_full_i_ready", 32'(i_ready), 32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_o_valid", 32'(o_valid), 32'd0);
    chk("ar_i_ready", 32'(i_ready), 32'd1);
    chk("ar_o_data", 32'(o_data), 32'd0);
    exp_q.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    drive(1'b1, 8'h7E, 1'b0, 1'b1);
    chk("ar_rel_i_ready", 32'(i_ready), 32'd1);
    drive(1'b0, 8'h00, 1'b0, 1'b1);
    chk("ar_7e_o_valid", 32'(o_valid), 32'd1);
    chk("ar_7e_o_data", 32'(o_data), 32'h7E);
    drive(1'b0, 8'h00, 1'b0, 1'b1);
    chk("ar_done_o_valid", 32'(o_valid), 32'd0);

`ifdef COND_SELECT_SKID_CNT_EN
    chk("cnt_one", 32'(o_xfer_cnt), 32'd1);
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, 8'(8'h80 + i), 1'b0, 1'b1);
      if (i == 13) begin
        chk("cnt_mid", 32'(o_xfer_cnt), 32'd13);
      end
    end
    drive(1'b0, 8'h00, 1'b0, 1'b1);
    drive(1'b0, 8'h00, 1'b0, 1'b1);
    chk("cnt_sat", 32'(o_xfer_cnt), 32'd15);
    drive(1'b1, 8'h99, 1'b0, 1'b0);
    drive(1'b0, 8'h00, 1'b1, 1'b1);
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    chk("cnt_flush", 32'(o_xfer_cnt), 32'd0);
    chk("cnt_flush_o_valid", 32'(o_valid), 32'd0);
`endif

    repeat (3) drive(1'b0, 8'h00, 1'b0, 1'b1);
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
